div_share_scheduler: RTL and testbench

// - Shares one iterative 64-bit divider between NUM_REQ reservation stations (RS).
// - Round-robin arbitration; holds the winner's commands/tag; sequences the divider

---
 rtl/div_share_scheduler.sv | 91 +++++++++
 tb/tb_div_share_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_scheduler.sv
// div_share_scheduler: round-robin share of one iterative divider among NUM_REQ RSs; optional DIV_ZERO_BYPASS_EN skips the divider for zero divisors
module div_share_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize+1)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            readyRS_i,
  input  logic [NUM_REQ*64-1:0]         rsVal1_i,
  input  logic [NUM_REQ*64-1:0]         rsVal2_i,
  input  logic [NUM_REQ*10-1:0]         rsCommands_i,
  input  logic [NUM_REQ*ROBsizeLog-1:0] rsTag_i,
  output logic [NUM_REQ-1:0]            stallRS_o,
  output logic                          divValidIn_o,
  output logic [63:0]                   divDividend_o,
  output logic [63:0]                   divDivisor_o,
  input  logic                          divValidOut_i,
  input  logic [63:0]                   divQuotient_i,
  input  logic                          canGo_i,
  output logic [63:0]                   executeVal_o,
  output logic [9:0]                    executeCommands_o,
  output logic [ROBsizeLog-1:0]         executeTag_o,
  output logic [3:0]                    executeFlags_o,
  output logic                          valid_o
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] rr_ptr, win, win_inc;
  logic found, zero_div, grant;
  int idx;
  // scan from rr_ptr upward, wrapping, and take the first ready RS
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      idx = idx >= NUM_REQ ? idx - NUM_REQ : idx;
      if (!found && readyRS_i[idx]) begin
        found = 1'b1;
        win = PW'(idx);
      end
    end
  end
  assign divDividend_o = rsVal1_i[64*win +: 64];
  assign divDivisor_o  = rsVal2_i[64*win +: 64];
  assign win_inc       = int'(win) == NUM_REQ-1 ? '0 : win + 1'b1;
  assign grant         = state == IDLE && found;
  assign valid_o       = state == DONE;
`ifdef DIV_ZERO_BYPASS_EN
  assign zero_div = divDivisor_o == '0;
`else
  assign zero_div = 1'b0;
`endif
  always_ff @(posedge clk_i)
    state <= reset_i ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    stallRS_o = '1;
    divValidIn_o = 1'b0;
    case (state)
      IDLE: if (found) begin
        stallRS_o[win] = 1'b0;
        divValidIn_o = !zero_div;
        state_nxt = zero_div ? DONE : BUSY;
      end
      BUSY: state_nxt = divValidOut_i ? DONE : BUSY;
      DONE: state_nxt = canGo_i ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr <= '0;
      executeVal_o <= '0;
      executeCommands_o <= '0;
      executeTag_o <= '0;
      executeFlags_o <= '0;
    end else if (grant) begin
      rr_ptr <= win_inc;
      executeCommands_o <= rsCommands_i[10*win +: 10];
      executeTag_o <= rsTag_i[ROBsizeLog*win +: ROBsizeLog];
      executeFlags_o <= {3'b000, zero_div};
      if (zero_div) executeVal_o <= '1;
    end else if (state == BUSY && divValidOut_i) begin
      executeVal_o <= divQuotient_i;
    end
  end
endmodule

// File: tb/tb_div_share_scheduler.sv
// tb_div_share_scheduler: directed checks of arbitration, divider handshake, hold, reset and zero-divisor handling
module tb_div_share_scheduler;
  localparam int RL = 6;
  logic clk, reset_i;
  logic [1:0] readyRS_i;
  logic [127:0] rsVal1_i, rsVal2_i;
  logic [19:0] rsCommands_i;
  logic [2*RL-1:0] rsTag_i;
  logic [1:0] stallRS_o;
  logic divValidIn_o, divValidOut_i, canGo_i, valid_o;
  logic [63:0] divDividend_o, divDivisor_o, divQuotient_i, executeVal_o;
  logic [9:0] executeCommands_o;
  logic [RL-1:0] executeTag_o;
  logic [3:0] executeFlags_o;
  int n_checks = 0;
  int n_fail = 0;

  div_share_scheduler #(.NUM_REQ(2), .ROBsize(32)) dut (
    .clk_i(clk), .reset_i(reset_i), .readyRS_i(readyRS_i), .rsVal1_i(rsVal1_i),
    .rsVal2_i(rsVal2_i), .rsCommands_i(rsCommands_i), .rsTag_i(rsTag_i),
    .stallRS_o(stallRS_o), .divValidIn_o(divValidIn_o), .divDividend_o(divDividend_o),
    .divDivisor_o(divDivisor_o), .divValidOut_i(divValidOut_i), .divQuotient_i(divQuotient_i),
    .canGo_i(canGo_i), .executeVal_o(executeVal_o), .executeCommands_o(executeCommands_o),
    .executeTag_o(executeTag_o), .executeFlags_o(executeFlags_o), .valid_o(valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_op(input int w, input logic [63:0] q);
    smp();
    chk("rr_stall", stallRS_o, w == 0 ? 2'b10 : 2'b01);
    chk("rr_start", divValidIn_o, 1);
    chk("rr_dividend", divDividend_o, w == 0 ? 100 : 200);
    cyc();
    smp();
    chk("rr_busy_stall", stallRS_o, 2'b11);
    cyc();
    divValidOut_i = 1'b1;
    divQuotient_i = q;
    cyc();
    divValidOut_i = 1'b0;
    smp();
    chk("rr_valid", valid_o, 1);
    chk("rr_val", executeVal_o, q);
    chk("rr_tag", executeTag_o, w == 0 ? 5 : 9);
    chk("rr_done_stall", stallRS_o, 2'b11);
    canGo_i = 1'b1;
    cyc();
    canGo_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    readyRS_i = '0;
    rsVal1_i = '0;
    rsVal2_i = '0;
    rsCommands_i = '0;
    rsTag_i = '0;
    divValidOut_i = 1'b0;
    divQuotient_i = '0;
    canGo_i = 1'b0;
    repeat (2) cyc();
    reset_i = 1'b0;
    smp();
    chk("rst_stall", stallRS_o, 2'b11);
    chk("rst_valid", valid_o, 0);
    chk("rst_val", executeVal_o, 0);
    chk("rst_flags", executeFlags_o, 0);
    repeat (3) cyc();
    smp();
    chk("idle_stall", stallRS_o, 2'b11);
    chk("idle_valid", valid_o, 0);
    chk("idle_start", divValidIn_o, 0);

    cyc();
    rsVal1_i[63:0] = 64'd15;
    rsVal2_i[63:0] = 64'd3;
    rsCommands_i[9:0] = 10'd10;
    rsTag_i[RL-1:0] = 6'd3;
    readyRS_i = 2'b01;
    smp();
    chk("t1_stall", stallRS_o, 2'b10);
    chk("t1_start", divValidIn_o, 1);
    chk("t1_dividend", divDividend_o, 15);
    chk("t1_divisor", divDivisor_o, 3);
    cyc();
    readyRS_i = 2'b00;
    smp();
    chk("t1_busy_start", divValidIn_o, 0);
    chk("t1_busy_stall", stallRS_o, 2'b11);
    chk("t1_busy_valid", valid_o, 0);
    repeat (7) cyc();
    divValidOut_i = 1'b1;
    divQuotient_i = 64'd5;
    cyc();
    divValidOut_i = 1'b0;
    divQuotient_i = '0;
    smp();
    chk("t1_valid", valid_o, 1);
    chk("t1_val", executeVal_o, 5);
    chk("t1_tag", executeTag_o, 3);
    chk("t1_cmd", executeCommands_o, 10);
    chk("t1_flags", executeFlags_o, 0);
    canGo_i = 1'b1;
    cyc();
    canGo_i = 1'b0;
    smp();
    chk("t1_idle_valid", valid_o, 0);
    chk("t1_idle_stall", stallRS_o, 2'b11);

    cyc();
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    rsVal1_i = {64'd200, 64'd100};
    rsVal2_i = {64'd8, 64'd4};
    rsCommands_i = {10'd2, 10'd1};
    rsTag_i = {6'd9, 6'd5};
    readyRS_i = 2'b11;
    do_op(0, 64'd25);
    do_op(1, 64'd25);
    do_op(0, 64'd26);
    do_op(1, 64'd27);

    smp();
    chk("hold_grant_stall", stallRS_o, 2'b10);
    cyc();
    readyRS_i = 2'b00;
    cyc();
    divValidOut_i = 1'b1;
    divQuotient_i = 64'd33;
    cyc();
    divValidOut_i = 1'b0;
    readyRS_i = 2'b11;
    for (int i = 0; i < 20; i++) begin
      smp();
      chk("hold_valid", valid_o, 1);
      chk("hold_val", executeVal_o, 33);
      chk("hold_tag", executeTag_o, 5);
      chk("hold_stall", stallRS_o, 2'b11);
      chk("hold_start", divValidIn_o, 0);
      divValidOut_i = (i == 5);
      divQuotient_i = 64'd99;
      cyc();
    end
    divValidOut_i = 1'b0;
    readyRS_i = 2'b00;
    canGo_i = 1'b1;
    cyc();
    canGo_i = 1'b0;

    readyRS_i = 2'b01;
    smp();
    chk("rb_grant_stall", stallRS_o, 2'b10);
    cyc();
    readyRS_i = 2'b00;
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    divValidOut_i = 1'b1;
    divQuotient_i = 64'd77;
    cyc();
    divValidOut_i = 1'b0;
    smp();
    chk("rb_valid", valid_o, 0);
    chk("rb_stall", stallRS_o, 2'b11);
    chk("rb_val", executeVal_o, 0);
    readyRS_i = 2'b01;
    #1;
    chk("rb_idle_stall", stallRS_o, 2'b10);
    chk("rb_idle_start", divValidIn_o, 1);
    readyRS_i = 2'b00;
    cyc();

    rsVal1_i[127:64] = 64'd7;
    rsVal2_i[127:64] = 64'd0;
    rsTag_i[2*RL-1:RL] = 6'd12;
    readyRS_i = 2'b10;
    smp();
    chk("z_stall", stallRS_o, 2'b01);
`ifdef DIV_ZERO_BYPASS_EN
    chk("z_start", divValidIn_o, 0);
    cyc();
    readyRS_i = 2'b00;
    smp();
    chk("z_valid", valid_o, 1);
    chk("z_val", executeVal_o, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("z_flags", executeFlags_o, 4'b0001);
    chk("z_tag", executeTag_o, 12);
`else
    chk("z_start", divValidIn_o, 1);
    chk("z_divisor", divDivisor_o, 0);
    cyc();
    readyRS_i = 2'b00;
    smp();
    chk("z_busy_valid", valid_o, 0);
    cyc();
    divValidOut_i = 1'b1;
    divQuotient_i = 64'h1234;
    cyc();
    divValidOut_i = 1'b0;
    smp();
    chk("z_valid", valid_o, 1);
    chk("z_val", executeVal_o, 64'h1234);
    chk("z_flags", executeFlags_o, 0);
    chk("z_tag", executeTag_o, 12);
`endif
    canGo_i = 1'b1;
    cyc();
    canGo_i = 1'b0;
    readyRS_i = 2'b01;
    smp();
    chk("zc_stall", stallRS_o, 2'b10);
    chk("zc_start", divValidIn_o, 1);
    cyc();
    readyRS_i = 2'b00;
    smp();
    chk("zc_flags", executeFlags_o, 0);
    chk("zc_tag", executeTag_o, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
